// File: rtl/reg_file_pkg.sv
// Shared widths and sizing helpers for the scoreboarded register file.
// Both the storage top level and its scoreboard size themselves from these.
package reg_file_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One extra bit so a full register file can be counted without wrapping.
    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Reservation scoreboard: one busy bit per register, issue arbitration
// and a running count of outstanding reservations.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                         clk,
    input  logic                         nClear,
    input  logic                         load,
    input  logic [ADDR_W-1:0]            Caddr,
    input  logic                         issue,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic [ADDR_W-1:0]            Aaddr,
    input  logic [ADDR_W-1:0]            Baddr,
    output logic                         issue_ack,
    output logic                         A_busy,
    output logic                         B_busy,
    output logic [cnt_width(ADDR_W)-1:0] busy_cnt
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam int CNT_W = cnt_width(ADDR_W);

    logic [DEPTH-1:0] busy;
    logic             issue_zero;
    logic             a_zero;
    logic             b_zero;
    logic             wb_frees_issue;
    logic             set_new;
    logic             clr_eff;

    assign issue_zero = ZERO_REG && (issue_addr == '0);
    assign a_zero     = ZERO_REG && (Aaddr == '0);
    assign b_zero     = ZERO_REG && (Baddr == '0);

    // A same-cycle write-back to the requested register frees it before the issue looks.
    assign wb_frees_issue = load && (Caddr == issue_addr);
    assign issue_ack      = issue && !issue_zero && (!busy[issue_addr] || wb_frees_issue);

    assign set_new = issue_ack && !busy[issue_addr];
    assign clr_eff = load && busy[Caddr] && !(issue_ack && (issue_addr == Caddr));

    assign A_busy = busy[Aaddr] && !a_zero && !(load && (Caddr == Aaddr));
    assign B_busy = busy[Baddr] && !b_zero && !(load && (Caddr == Baddr));

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (clr_eff)
                busy[Caddr] <= 1'b0;
            if (issue_ack)
                busy[issue_addr] <= 1'b1;
            if (set_new && !clr_eff)
                busy_cnt <= busy_cnt + CNT_W'(1);
            else if (!set_new && clr_eff)
                busy_cnt <= busy_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with write bypass, optional hardwired
// zero register and a reservation scoreboard for in-flight destinations.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter int DBG_IDX  = 6
) (
    input  logic                         clk,
    input  logic                         nClear,
    input  logic [ADDR_W-1:0]            Aaddr,
    input  logic [ADDR_W-1:0]            Baddr,
    output logic [DATA_W-1:0]            A,
    output logic [DATA_W-1:0]            B,
    output logic                         A_busy,
    output logic                         B_busy,
    input  logic [ADDR_W-1:0]            Caddr,
    input  logic [DATA_W-1:0]            C,
    input  logic                         load,
    input  logic                         issue,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ack,
    output logic [cnt_width(ADDR_W)-1:0] busy_cnt,
    output logic [7:0]                   dbg
);

    localparam int                DEPTH   = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] DBG_SEL = ADDR_W'(DBG_IDX);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (load && !(ZERO_REG && (Caddr == '0))) begin
            regs[Caddr] <= C;
        end
    end

    // Zero-register masking has the last word over bypass.
    always_comb begin
        A = regs[Aaddr];
        B = regs[Baddr];
        if (load && (Caddr == Aaddr))
            A = C;
        if (load && (Caddr == Baddr))
            B = C;
        if (ZERO_REG && (Aaddr == '0))
            A = '0;
        if (ZERO_REG && (Baddr == '0))
            B = '0;
    end

    assign dbg = regs[DBG_SEL][7:0];

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .nClear    (nClear),
        .load      (load),
        .Caddr     (Caddr),
        .issue     (issue),
        .issue_addr(issue_addr),
        .Aaddr     (Aaddr),
        .Baddr     (Baddr),
        .issue_ack (issue_ack),
        .A_busy    (A_busy),
        .B_busy    (B_busy),
        .busy_cnt  (busy_cnt)
    );

endmodule
